alu_decoder: RTL and testbench
==============================

ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk  input  1  rising-edge clock`.
REQ-002 `rst  input  1  asynchronous active-high reset`.
REQ-003 `instr_i  input  32  RV32I instruction word`.
REQ-004 `rs1_data_i  input  32  rs1 register value`.
REQ-005 `rs2_data_i  input  32  rs2 register value`.
REQ-006 `in_valid_i  input  1  upstream offers instruction`.
REQ-007 `in_ready_o  output  1  block accepts instruction`.
REQ-008 `a_o  output  32  ALU operand A`.
REQ-009 `b_o  output  32  ALU operand B`.
REQ-010 `alucontrol_o  output  4  ALU op code: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101`.
REQ-011 `rd_o  output  5  destination register`.
REQ-012 `illegal_o  output  1  current output entry is an illegal encoding`.
REQ-013 `out_valid_o  output  1  output entry valid`.
REQ-014 `out_ready_i  input  1  ALU stage consumes entry`.

Function
REQ-015 Transfer on each side SHALL occur on a rising clk edge where valid and ready are both 1.
REQ-016 Decoded entries SHALL be held in a 2-entry FIFO (skid buffer); outputs SHALL come from the head entry registers only, with no combinational path from instr_i to the outputs.
REQ-017 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL present out_valid_o=1 after edge N when the FIFO was empty.
REQ-018 in_ready_o SHALL be registered and SHALL equal 1 exactly when the FIFO occupancy is below 2.
REQ-019 When the FIFO is full, in_ready_o SHALL be 0 and an out_ready_i pop SHALL raise in_ready_o on the next cycle; a simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-020 While out_valid_o=1 and out_ready_i=0, all outputs SHALL hold stable.
REQ-021 Read/write pointers SHALL be 1 bit each and wrap from 1 to 0.
REQ-022 Decoding SHALL set alucontrol_o = {bit30 qualifier, funct3}. The qualifier is instr[30] for OP (0110011), and for OP-IMM (0010011) when funct3=101; otherwise it is 0.
REQ-023 a_o SHALL be rs1_data_i.
REQ-024 For OP, b_o SHALL be rs2_data_i.
REQ-025 For OP-IMM with funct3=001 or 101, b_o SHALL be {27'b0, instr[24:20]}.
REQ-026 For other OP-IMM, b_o SHALL be sign-extended instr[31:20].
REQ-027 rd_o SHALL be instr[11:7].
REQ-028 The following encodings SHALL be illegal:
- opcode not OP/OP-IMM;
- OP with funct7 not 0000000/0100000;
- OP with funct7=0100000 and funct3 not 000/101;
- OP-IMM funct3=001 with funct7≠0000000;
- OP-IMM funct3=101 with funct7 not 0000000/0100000.
REQ-029 Illegal entries SHALL still traverse the FIFO in order with illegal_o=1, alucontrol_o=0000 and b_o=0.

Reset
REQ-030 While rst=1:
- occupancy and pointers SHALL be 0;
- out_valid_o, in_ready_o, illegal_o, alucontrol_o, a_o, b_o and rd_o SHALL be 0.
REQ-031 Asserting rst mid-operation SHALL discard all buffered entries immediately.
REQ-032 in_ready_o SHALL rise to 1 on the first clk edge after rst deasserts.

Configuration
REQ-033 With `ALU_DECODER_ILLEGAL_EN` defined, the decoder SHALL implement REQ-028/REQ-029.
REQ-034 Without `ALU_DECODER_ILLEGAL_EN`, illegal_o SHALL be tied 0 and the following SHALL decode per REQ-022–REQ-026 using funct3 and instr[30] only:
- any OP/OP-IMM encoding;
- any other opcode.

Verification
REQ-035 ADD: 0x002081B3, rs1=5, rs2=7 -> 1 cycle later out_valid_o=1, alucontrol_o=0000, a_o=5, b_o=7, rd_o=3.
REQ-036 SUB and SRAI back-to-back with out_ready_i=1:
- 0x40208133 -> alucontrol_o=1000, rd_o=2;
- then 0x40335293 -> alucontrol_o=1101, b_o=3, rd_o=5.
REQ-037 ADDI: 0xFFF00093 -> alucontrol_o=0000, b_o=0xFFFFFFFF, rd_o=1.
REQ-038 Back-pressure with out_ready_i=0:
- push 3 valid instructions -> in_ready_o=0 after 2 accepts, outputs stable;
- release out_ready_i -> entries drain in order, the third is accepted after the first pop.
REQ-039 Illegal JAL: 0x0000006F with ALU_DECODER_ILLEGAL_EN -> illegal_o=1, alucontrol_o=0000; without the macro -> illegal_o=0.
REQ-040 Reset mid-operation: assert rst with 2 entries buffered -> out_valid_o=0 immediately; after release, first accepted instruction emerges with 1-cycle latency.

Source files
------------

// File: rtl/alu_decoder.sv
// RV32I OP/OP-IMM operand/control decoder feeding a 2-entry skid FIFO; outputs come from the head entry.
// Defining ALU_DECODER_ILLEGAL_EN enables illegal-encoding detection; otherwise illegal_o stays 0.
module alu_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [3:0]  alucontrol_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  typedef struct packed {
    logic        illegal;
    logic [3:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } entry_t;

  logic [2:0] f3_s;
  logic       is_op_s;
  logic       is_shift_s;
  logic       bad_s;
  entry_t     dec_s;
  entry_t     head_s;
  entry_t     mem_r [0:1];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic [1:0] count_next_s;
  logic       out_valid_r;
  logic       in_ready_r;
  logic       push_s;
  logic       pop_s;
  logic       unused_rs1_field;

  assign f3_s       = instr_i[14:12];
  assign is_op_s    = (instr_i[6:0] == 7'b0110011);
  assign is_shift_s = (f3_s == 3'b001) || (f3_s == 3'b101);
  assign unused_rs1_field = ^instr_i[19:15];

`ifdef ALU_DECODER_ILLEGAL_EN
  logic [6:0] f7_s;
  logic       is_opi_s;
  assign f7_s     = instr_i[31:25];
  assign is_opi_s = (instr_i[6:0] == 7'b0010011);
  assign bad_s = (!is_op_s && !is_opi_s)
              || (is_op_s && (f7_s != 7'b0000000) && (f7_s != 7'b0100000))
              || (is_op_s && (f7_s == 7'b0100000) && (f3_s != 3'b000) && (f3_s != 3'b101))
              || (is_opi_s && (f3_s == 3'b001) && (f7_s != 7'b0000000))
              || (is_opi_s && (f3_s == 3'b101) && (f7_s != 7'b0000000) && (f7_s != 7'b0100000));
`else
  assign bad_s = 1'b0;
`endif

  // Decode the offered instruction; anything that is not OP is decoded like OP-IMM
  always_comb begin
    dec_s         = '0;
    dec_s.illegal = bad_s;
    dec_s.a       = rs1_data_i;
    dec_s.rd      = instr_i[11:7];
    if (bad_s) begin
      dec_s.alucontrol = 4'b0000;
      dec_s.b          = 32'h0000_0000;
    end else begin
      dec_s.alucontrol = {((is_op_s || (f3_s == 3'b101)) ? instr_i[30] : 1'b0), f3_s};
      if (is_op_s) begin
        dec_s.b = rs2_data_i;
      end else if (is_shift_s) begin
        dec_s.b = {27'b0, instr_i[24:20]};
      end else begin
        dec_s.b = {{20{instr_i[31]}}, instr_i[31:20]};
      end
    end
  end

  assign push_s = in_valid_i & in_ready_r;
  assign pop_s  = out_valid_r & out_ready_i;

  // Occupancy after this edge's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= dec_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != 2'd0);
      in_ready_r  <= (count_next_s != 2'd2);
    end
  end

  assign head_s       = mem_r[rd_ptr_r];
  assign in_ready_o   = in_ready_r;
  assign out_valid_o  = out_valid_r;
  assign illegal_o    = head_s.illegal;
  assign alucontrol_o = head_s.alucontrol;
  assign a_o          = head_s.a;
  assign b_o          = head_s.b;
  assign rd_o         = head_s.rd;

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: directed vectors push expectations, a monitor pops and compares.
module tb_alu_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [3:0]  alucontrol_o;
  logic [4:0]  rd_o;
  logic        illegal_o;
  logic        out_valid_o;
  logic        out_ready_i;

`ifdef ALU_DECODER_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .instr_i      (instr_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_o          (a_o),
    .b_o          (b_o),
    .alucontrol_o (alucontrol_o),
    .rd_o         (rd_o),
    .illegal_o    (illegal_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Offer one instruction (holding it until accepted) and queue its expected decode
  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [3:0] alu, input logic [31:0] b, input logic [4:0] rd,
                      input logic ill);
    exp_t e;
    int   budget = 0;
    instr_i    = ins;
    rs1_data_i = r1;
    rs2_data_i = r2;
    in_valid_i = 1'b1;
    while (!in_ready_o && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready_o) begin
      chk("send_timeout", 80'd0, 80'd1);
      in_valid_i = 1'b0;
      return;
    end
    e.alu = alu; e.a = r1; e.b = b; e.rd = rd; e.ill = ill;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 80'(sb.size()), 80'd0);
  endtask

  // Monitor: compare entries as they are consumed, and check holding while stalled
  exp_t        mon_e;
  logic        stalled = 1'b0;
  logic [79:0] snap;
  logic [79:0] cur;
  initial begin
    forever begin
      @(negedge clk);
      cur = {6'd0, illegal_o, alucontrol_o, a_o, b_o, rd_o};
      if (rst) begin
        stalled = 1'b0;
      end else if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 80'd1, 80'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("alucontrol", 80'(alucontrol_o), 80'(mon_e.alu));
          chk("a", 80'(a_o), 80'(mon_e.a));
          chk("b", 80'(b_o), 80'(mon_e.b));
          chk("rd", 80'(rd_o), 80'(mon_e.rd));
          chk("illegal", 80'(illegal_o), 80'(mon_e.ill));
        end
        stalled = 1'b0;
      end else if (out_valid_o) begin
        if (stalled) chk("hold_stable", cur, snap);
        snap    = cur;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    instr_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 80'(out_valid_o), 80'd0);
    chk("rst_in_ready", 80'(in_ready_o), 80'd0);
    chk("rst_illegal", 80'(illegal_o), 80'd0);
    chk("rst_alucontrol", 80'(alucontrol_o), 80'd0);
    chk("rst_a", 80'(a_o), 80'd0);
    chk("rst_b", 80'(b_o), 80'd0);
    chk("rst_rd", 80'(rd_o), 80'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 80'(in_ready_o), 80'd1);
    out_ready_i = 1'b1;

    send(32'h002081B3, 32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1'b0);           // ADD
    chk("add_latency", 80'(out_valid_o), 80'd1);
    send(32'h40208133, 32'd10, 32'd3, 4'b1000, 32'd3, 5'd2, 1'b0);          // SUB
    send(32'h40335293, 32'hFFFF_FFF0, 32'd9, 4'b1101, 32'd3, 5'd5, 1'b0);   // SRAI
    send(32'hFFF00093, 32'd100, 32'd1, 4'b0000, 32'hFFFF_FFFF, 5'd1, 1'b0); // ADDI -1
    send(32'h0000006F, 32'h11, 32'h22, 4'b0000, 32'd0, 5'd0, ILL_EN);       // JAL
    send(32'h40209133, 32'd1, 32'd4, ILL_EN ? 4'b0000 : 4'b1001,
         ILL_EN ? 32'd0 : 32'd4, 5'd2, ILL_EN);                              // OP f7=0100000 f3=001
    send(32'h40309313, 32'd8, 32'd0, ILL_EN ? 4'b0000 : 4'b0001,
         ILL_EN ? 32'd0 : 32'd3, 5'd6, ILL_EN);                              // SLLI with bit30 set
    send(32'h00415393, 32'hF0, 32'd0, 4'b0101, 32'd4, 5'd7, 1'b0);          // SRLI
    drain();

    // Back-pressure: fill both entries, third waits for the first pop
    out_ready_i = 1'b0;
    send(32'h0020C233, 32'h0F0F, 32'h00FF, 4'b0100, 32'h00FF, 5'd4, 1'b0);  // XOR
    send(32'h8001E413, 32'h1234, 32'd0, 4'b0110, 32'hFFFF_F800, 5'd8, 1'b0); // ORI -2048
    chk("full_in_ready", 80'(in_ready_o), 80'd0);
    fork
      send(32'h002081B3, 32'd9, 32'd1, 4'b0000, 32'd1, 5'd3, 1'b0);
      begin
        repeat (2) begin @(posedge clk); #1; end
        chk("full_in_ready_held", 80'(in_ready_o), 80'd0);
        chk("full_out_valid", 80'(out_valid_o), 80'd1);
        out_ready_i = 1'b1;
      end
    join
    drain();

    // Reset with two entries buffered
    out_ready_i = 1'b0;
    send(32'h40208133, 32'd50, 32'd20, 4'b1000, 32'd20, 5'd2, 1'b0);
    send(32'hFFF00093, 32'd60, 32'd0, 4'b0000, 32'hFFFF_FFFF, 5'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 80'(out_valid_o), 80'd0);
    chk("midrst_in_ready", 80'(in_ready_o), 80'd0);
    chk("midrst_a", 80'(a_o), 80'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_midrst", 80'(in_ready_o), 80'd1);
    out_ready_i = 1'b1;
    send(32'h002081B3, 32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1'b0);
    chk("post_rst_latency", 80'(out_valid_o), 80'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
